uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Sequencing and sharing controller for the UART transmit path. Accepts 20-bit messages from `NUM_REQ` independent requesters, picks one per frame with round-robin arbitration, and serialises it as a 22-bit frame: start bit, 20 data bits LSB first, stop bit. Bit timing comes from an internal baud divider. The block sits between the on-chip message producers and the board TX pin, replacing ad-hoc single-producer use of the transmitter.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, must be ≥ 2.
- `DATA_W`, default 20: message payload width.
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit, must be ≥ 1.

Ports:
- `clock`, input, 1: sole clock; all logic on posedge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, `NUM_REQ`: request per requester; held with `message` until acked.
- `message`, input, [`NUM_REQ`][`DATA_W`]: payload per requester; sampled only on grant.
- `ack`, output, `NUM_REQ`: one-hot, one-cycle pulse; message accepted.
- `serialOut`, output, 1: TX line; idle high.
- `busy`, output, 1: frame in progress.
- `activeId`, output, clog2(`NUM_REQ`): index of the requester whose frame is on the line.
- `frameDone`, output, 1: one-cycle pulse after the last stop-bit cycle.

## Operation
- Reset values (cycle after `reset` is sampled high): `serialOut`=1, `busy`=0, `ack`=0, `frameDone`=0, `activeId`=0, state=IDLE, round-robin pointer=`NUM_REQ`-1 (requester 0 wins first).
- States:
  - IDLE: line high. If `req`≠0, the winner is the first set bit searching upward from pointer+1 with wrap-around. On the clock edge:
    - frame `{1'b1, message[w], 1'b0}` is loaded into the shift register;
    - `ack[w]` is set for exactly one cycle;
    - `activeId`=w, pointer=w, `busy`=1, state becomes SEND.
  - SEND: `serialOut` = shift register bit 0. The baud counter counts 0..`CLKS_PER_BIT`-1. At the terminal count, the register shifts right (fill 1) and the bit counter increments. After bit 21 completes, state returns to IDLE, `busy`=0 and `frameDone`=1 for one cycle.
- Arbitration happens only in IDLE. Requests arriving during SEND wait.
- A `req` dropped before its grant is simply not served. No error is raised.
- Simultaneous `frameDone` and new request: arbitration occurs in that same IDLE cycle. The minimum line-high gap between frames is therefore 1 cycle beyond the stop bit.
- Reset mid-frame: the frame is abandoned. `serialOut` returns high the next cycle, no `frameDone` is emitted, and the pointer resets.
- Widths:
  - bit counter is clog2(22)=5 bits and saturates at 21 only by state exit;
  - baud counter is max(1, clog2(`CLKS_PER_BIT`)) bits and wraps to 0 at the terminal count.

## Timing
- Request seen in IDLE at cycle t:
  - `ack` is high at t+1;
  - start bit is on `serialOut` during t+1 … t+`CLKS_PER_BIT`.
- Data bit k (0-based) occupies cycles t+1+(k+1)·`CLKS_PER_BIT` … for `CLKS_PER_BIT` cycles.
- The stop bit ends at t+22·`CLKS_PER_BIT`. `frameDone` and `busy`=0 occur at t+22·`CLKS_PER_BIT`+1.
- Back-to-back throughput: one frame per 22·`CLKS_PER_BIT`+1 cycles.
- All outputs are registered. There is no combinational path from `req` to `ack` or to `serialOut`.

## Structure
- Shared package `uart_pkg` holds:
  - `FRAME_W`=22, `DATA_W`=20, `START_BIT`=1'b0, `STOP_BIT`=1'b1;
  - the state enum `tx_state_t` {IDLE, SEND}.
- Sub-module `rr_arbiter` #(`NUM_REQ`): owns the pointer register and produces the one-hot grant plus index. It has `update` and `reset` inputs. The scheduler owns the counters, the shift register and the FSM.

## Test plan
- Single request, `CLKS_PER_BIT`=8, `req`[0]=1, message 20'hA5A5A at cycle t:
  - `ack`[0] is high only at t+1;
  - `serialOut` is 0 for t+1..t+8, then data bits 0,1,0,1,1,0,1,0,… (LSB first, 8 cycles each), then 1;
  - `frameDone` pulses at t+177.
- All four requests high at once, each holding until acked: grant order is 0,1,2,3. Consecutive `ack` pulses are 177 cycles apart, and `activeId` tracks each frame.
- Requesters 0 and 2 held high continuously: grants alternate 0,2,0,2. Requesters 1 and 3 never get `ack`.
- `reset` asserted during data bit 10 with requester 3 active:
  - next cycle `serialOut`=1, `busy`=0, no `frameDone`;
  - after release with `req`=4'b1010, requester 1 is granted first.
- `CLKS_PER_BIT`=1, `req`[1] with message 20'hFFFFF: line reads 0, then twenty 1s, then 1. `frameDone` at t+23.
- `req`[2] pulsed for one cycle while a frame is in SEND, then dropped: no `ack`[2] and no extra frame. The line stays high after the current `frameDone`.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Frame constants and TX state type shared by the UART scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int   FRAME_W   = 22;
  localparam int   DATA_W    = 20;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter; search starts one above the last winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_update,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  logic [c_IDX_W-1:0] r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_IDX_W-1:0] w_cand;
  logic               w_found;

  // Walk pointer+1 .. pointer+NUM_REQ with wrap; the first set request wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        w_grant[w_cand] = 1'b1;
        w_idx           = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= c_IDX_W'(NUM_REQ - 1);
    end else if (i_update && w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin shared UART transmitter: start + DATA_W LSB-first + stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 20,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    message,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              serialOut,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        activeId,
  output logic                              frameDone
);

  localparam int c_IDX_W   = $clog2(NUM_REQ);
  localparam int c_FRAME_W = DATA_W + 2;
  localparam int c_BIT_W   = $clog2(c_FRAME_W);
  localparam int c_BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(c_FRAME_W - 1);

  tx_state_t             r_state;
  logic [c_FRAME_W-1:0]  r_shift;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [c_BIT_W-1:0]    r_bit;
  logic                  r_busy;
  logic                  r_done;
  logic [NUM_REQ-1:0]    r_ack;
  logic [c_IDX_W-1:0]    r_active_id;

  logic [NUM_REQ-1:0]    w_grant;
  logic [c_IDX_W-1:0]    w_grant_idx;
  logic                  w_update;

  assign w_update = (r_state == IDLE) && (|req);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .clk         (clock),
    .rst         (reset),
    .i_req       (req),
    .i_update    (w_update),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // The line is driven straight from shift bit 0; an all-ones register idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '1;
      r_baud      <= '0;
      r_bit       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ack       <= '0;
      r_active_id <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_shift     <= {STOP_BIT, message[w_grant_idx], START_BIT};
            r_ack       <= w_grant;
            r_active_id <= w_grant_idx;
            r_busy      <= 1'b1;
            r_baud      <= '0;
            r_bit       <= '0;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (r_baud == c_BAUD_LAST) begin
            r_baud  <= '0;
            r_shift <= {STOP_BIT, r_shift[c_FRAME_W-1:1]};
            if (r_bit == c_BIT_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign serialOut = r_shift[0];
  assign busy      = r_busy;
  assign activeId  = r_active_id;
  assign frameDone = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler (CPB=8 and CPB=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [3:0]       req;
  logic [3:0][19:0] message;
  logic [3:0]       ack;
  logic             serialOut, busy, frameDone;
  logic [1:0]       activeId;

  logic             reset1;
  logic [3:0]       req1;
  logic [3:0][19:0] message1;
  logic [3:0]       ack1;
  logic             serialOut1, busy1, frameDone1;
  logic [1:0]       activeId1;

  int errors = 0;
  int checks = 0;

  localparam logic [19:0] c_M0 = 20'hA5A5A;
  localparam logic [19:0] c_M1 = 20'h12345;
  localparam logic [19:0] c_M2 = 20'h0F0F0;
  localparam logic [19:0] c_M3 = 20'hFEDCB;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(20), .CLKS_PER_BIT(8)) dut8 (
    .clock(clock), .reset(reset), .req(req), .message(message), .ack(ack),
    .serialOut(serialOut), .busy(busy), .activeId(activeId), .frameDone(frameDone)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(20), .CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset1), .req(req1), .message(message1), .ack(ack1),
    .serialOut(serialOut1), .busy(busy1), .activeId(activeId1), .frameDone(frameDone1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    req   = 4'b0000;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Caller sets req/message just after an edge; the next edge is the grant edge t,
  // so loop index c is the cycle offset from t.
  task automatic run_frame(input logic [3:0] exp_ack, input logic [1:0] exp_id,
                           input logic [19:0] msg, input logic [3:0] drop_mask,
                           input logic [3:0] pulse_mask);
    logic [21:0] frame;
    logic        exp_ser;
    logic [3:0]  exp_a;
    frame = {1'b1, msg, 1'b0};
    for (int c = 1; c <= 177; c++) begin
      tick;
      exp_ser = (c <= 176) ? frame[(c-1)/8] : 1'b1;
      exp_a   = (c == 1) ? exp_ack : 4'b0000;
      checks++;
      if (serialOut !== exp_ser) begin
        errors++;
        $display("FAIL serial id%0d c=%0d: got %b expected %b", exp_id, c, serialOut, exp_ser);
      end
      checks++;
      if (ack !== exp_a) begin
        errors++;
        $display("FAIL ack id%0d c=%0d: got %b expected %b", exp_id, c, ack, exp_a);
      end
      checks++;
      if (frameDone !== (c == 177)) begin
        errors++;
        $display("FAIL frameDone id%0d c=%0d: got %b expected %b", exp_id, c, frameDone, (c == 177));
      end
      checks++;
      if (busy !== (c <= 176)) begin
        errors++;
        $display("FAIL busy id%0d c=%0d: got %b expected %b", exp_id, c, busy, (c <= 176));
      end
      if (c == 1 || c == 100) begin
        checks++;
        if (activeId !== exp_id) begin
          errors++;
          $display("FAIL activeId c=%0d: got %0d expected %0d", c, activeId, exp_id);
        end
      end
      if (c == 1)  req = req & ~drop_mask;
      if (c == 60) req = req | pulse_mask;
      if (c == 61) req = req & ~pulse_mask;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    reset1  = 1'b1;
    req     = 4'b0000;
    req1    = 4'b0000;
    message = '0;
    message1 = '0;
    tick;
    tick;
    checks++;
    if ({serialOut, busy, ack, frameDone, activeId} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset8: got ser=%b busy=%b ack=%b done=%b id=%0d expected 1 0 0000 0 0",
               serialOut, busy, ack, frameDone, activeId);
    end
    checks++;
    if ({serialOut1, busy1, ack1, frameDone1, activeId1} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset1: got ser=%b busy=%b ack=%b done=%b id=%0d expected 1 0 0000 0 0",
               serialOut1, busy1, ack1, frameDone1, activeId1);
    end
    reset  = 1'b0;
    reset1 = 1'b0;
  endtask

  task automatic test_single;
    apply_reset;
    message[0] = c_M0;
    req = 4'b0001;
    run_frame(4'b0001, 2'd0, c_M0, 4'b0001, 4'b0000);
  endtask

  task automatic test_back_to_back;
    apply_reset;
    message = {c_M3, c_M2, c_M1, c_M0};
    req = 4'b1111;
    run_frame(4'b0001, 2'd0, c_M0, 4'b0001, 4'b0000);
    run_frame(4'b0010, 2'd1, c_M1, 4'b0010, 4'b0000);
    run_frame(4'b0100, 2'd2, c_M2, 4'b0100, 4'b0000);
    run_frame(4'b1000, 2'd3, c_M3, 4'b1000, 4'b0000);
  endtask

  task automatic test_alternate;
    req = 4'b0101;
    run_frame(4'b0001, 2'd0, c_M0, 4'b0000, 4'b0000);
    run_frame(4'b0100, 2'd2, c_M2, 4'b0000, 4'b0000);
    run_frame(4'b0001, 2'd0, c_M0, 4'b0000, 4'b0000);
    run_frame(4'b0100, 2'd2, c_M2, 4'b0101, 4'b0000);
  endtask

  task automatic test_dropped_req;
    req = 4'b0001;
    run_frame(4'b0001, 2'd0, c_M0, 4'b0001, 4'b0100);
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if ({serialOut, busy, ack} !== {1'b1, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL idle_after_drop c=%0d: got ser=%b busy=%b ack=%b expected 1 0 0000",
                 c, serialOut, busy, ack);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [21:0] frame;
    apply_reset;
    frame = {1'b1, c_M3, 1'b0};
    req = 4'b1000;
    for (int c = 1; c <= 92; c++) begin
      tick;
      if (c == 1) begin
        checks++;
        if (ack !== 4'b1000 || activeId !== 2'd3) begin
          errors++;
          $display("FAIL mid_grant: got ack=%b id=%0d expected 1000 3", ack, activeId);
        end
      end
    end
    checks++;
    if (serialOut !== frame[11]) begin
      errors++;
      $display("FAIL mid_bit10: got %b expected %b", serialOut, frame[11]);
    end
    reset = 1'b1;
    req   = 4'b1010;
    tick;
    checks++;
    if ({serialOut, busy, frameDone, ack} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL mid_reset: got ser=%b busy=%b done=%b ack=%b expected 1 0 0 0000",
               serialOut, busy, frameDone, ack);
    end
    reset = 1'b0;
    tick;
    checks++;
    if ({ack, activeId, frameDone, serialOut} !== {4'b0010, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_grant: got ack=%b id=%0d done=%b ser=%b expected 0010 1 0 0",
               ack, activeId, frameDone, serialOut);
    end
    apply_reset;
  endtask

  task automatic test_cpb1;
    logic exp_ser;
    message1[1] = 20'hFFFFF;
    req1 = 4'b0010;
    for (int c = 1; c <= 23; c++) begin
      tick;
      exp_ser = (c == 1) ? 1'b0 : 1'b1;
      checks++;
      if (serialOut1 !== exp_ser) begin
        errors++;
        $display("FAIL cpb1_serial c=%0d: got %b expected %b", c, serialOut1, exp_ser);
      end
      checks++;
      if (ack1 !== ((c == 1) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL cpb1_ack c=%0d: got %b expected %b", c, ack1, ((c == 1) ? 4'b0010 : 4'b0000));
      end
      checks++;
      if (frameDone1 !== (c == 23) || busy1 !== (c <= 22)) begin
        errors++;
        $display("FAIL cpb1_done c=%0d: got done=%b busy=%b expected %b %b",
                 c, frameDone1, busy1, (c == 23), (c <= 22));
      end
      if (c == 1) begin
        checks++;
        if (activeId1 !== 2'd1) begin
          errors++;
          $display("FAIL cpb1_id: got %0d expected 1", activeId1);
        end
        req1 = 4'b0000;
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_alternate;
    test_dropped_req;
    test_reset_midframe;
    test_cpb1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
